seq_ctrl: RTL and testbench

Instruction sequencer for the CPU core. It generates the `SequencerState` stream `q` that drives core enables, ALU timing and IP update. It adds run/halt control, RAM-busy stalls, a halt opcode, and cycle/instruction counters. It sits between the top level (external run/halt controls) and `core`, and replaces free-running state stepping.

---
 rtl/seq_ctrl_pkg.sv | 25 ++
 rtl/seq_ctrl_counters.sv | 37 +++
 rtl/seq_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the instruction sequencer: state encoding,
// opcode width and the default halt opcode.
package seq_ctrl_pkg;

  localparam int OPCODE_WIDTH = 8;
  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 8'hFF;

  // SHALT is appended after SNXT so the original encodings stay put
  typedef enum logic [3:0] {
    SRST   = 4'd0,
    SREAD  = 4'd1,
    SLOAD1 = 4'd2,
    SLOAD2 = 4'd3,
    SLOAD3 = 4'd4,
    SCALC  = 4'd5,
    SWRITE = 4'd6,
    SNXT   = 4'd7,
    SHALT  = 4'd8
  } SequencerState;

  function automatic logic is_active(input SequencerState s);
    return (s != SRST) && (s != SHALT);
  endfunction

endpackage

// File: rtl/seq_ctrl_counters.sv
// Performance counters for the sequencer: active cycles and retired
// instructions, both wrapping, with a synchronous clear that wins over counting.
module seq_counters
  import seq_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr_cnt,
  input  SequencerState        q,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [CNT_WIDTH-1:0] r_instr_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else if (clr_cnt) begin
      r_cycle_count <= '0;
      r_instr_count <= '0;
    end else begin
      if (is_active(q)) r_cycle_count <= r_cycle_count + ONE;
      if (q == SNXT)    r_instr_count <= r_instr_count + ONE;
    end
  end

  assign cycle_count = r_cycle_count;
  assign instr_count = r_instr_count;

endmodule

// File: rtl/seq_ctrl.sv
// Instruction sequencer with run/halt control, RAM-busy stalls and a halt opcode.
// Optional single-step support is compiled in with the SEQ_STEP_EN macro.
module seq_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = HALT_OPCODE_DEFAULT,
  parameter int                      CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    run,
  input  logic                    halt_req,
`ifdef SEQ_STEP_EN
  input  logic                    step,
`endif
  input  logic                    clr_cnt,
  input  logic                    ram_busy,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output SequencerState           q,
  output logic                    halted,
  output logic [CNT_WIDTH-1:0]    cycle_count,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  SequencerState r_q;
  logic          r_halted;
  logic          r_halt_pend;
  logic          r_halt_op;
  logic          r_run_q;
  logic          w_step;
  logic          w_step_mode;
  logic          w_run_rise;
  logic          w_stop;
  logic          w_resume;

`ifdef SEQ_STEP_EN
  logic r_step_mode;

  assign w_step      = step;
  assign w_step_mode = r_step_mode;

  // A step arms one-instruction mode; a run edge returns to free running
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_step_mode <= 1'b0;
    end else if (r_q == SHALT && !halt_req) begin
      if (step)            r_step_mode <= 1'b1;
      else if (w_run_rise) r_step_mode <= 1'b0;
    end
  end
`else
  assign w_step      = 1'b0;
  assign w_step_mode = 1'b0;
`endif

  assign w_run_rise = run && !r_run_q;
  // A halt_req arriving during SNXT itself still stops at this boundary
  assign w_stop     = r_halt_pend || halt_req || r_halt_op || w_step_mode;
  assign w_resume   = !halt_req && (w_step || w_run_rise);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q         <= SRST;
      r_halted    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_halt_op   <= 1'b0;
      r_run_q     <= 1'b0;
    end else begin
      r_run_q <= run;

      case (r_q)
        SRST:   if (run) r_q <= SREAD;
        SREAD:  r_q <= SLOAD1;
        SLOAD1: if (!ram_busy) r_q <= SLOAD2;
        SLOAD2: if (!ram_busy) r_q <= SLOAD3;
        SLOAD3: if (!ram_busy) r_q <= SCALC;
        SCALC:  if (!ram_busy) r_q <= SWRITE;
        SWRITE: if (!ram_busy) r_q <= SNXT;
        SNXT: begin
          if (w_stop) begin
            r_q      <= SHALT;
            r_halted <= 1'b1;
          end else begin
            r_q <= SREAD;
          end
        end
        SHALT: begin
          if (w_resume) begin
            r_q      <= SREAD;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_q      <= SRST;
          r_halted <= 1'b0;
        end
      endcase

      // A request seen while already halted is absorbed by staying in SHALT
      if (r_q == SNXT && w_stop)
        r_halt_pend <= 1'b0;
      else if (halt_req && is_active(r_q))
        r_halt_pend <= 1'b1;

      if (r_q == SWRITE && !ram_busy)
        r_halt_op <= (opcode == HALT_OPCODE);
      else if (r_q == SNXT)
        r_halt_op <= 1'b0;
    end
  end

  assign q      = r_q;
  assign halted = r_halted;

  seq_counters #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counters (
    .clk         (clk),
    .rstn        (rstn),
    .clr_cnt     (clr_cnt),
    .q           (r_q),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: an instruction-level model predicts q and the
// counters every cycle, directed scenarios add hand-computed literal expectations.
module tb_seq_ctrl;
  import seq_ctrl_pkg::*;

  localparam int CW  = 4;
  localparam int MOD = 1 << CW;
  localparam logic [7:0] HALT_OP = 8'hFF;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          run = 1'b0;
  logic          halt_req = 1'b0;
  logic          step = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          ram_busy = 1'b0;
  logic [7:0]    opcode = 8'h00;
  SequencerState q;
  logic          halted;
  logic [CW-1:0] cycle_count;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_ctrl #(
    .HALT_OPCODE (HALT_OP),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .run         (run),
    .halt_req    (halt_req),
`ifdef SEQ_STEP_EN
    .step        (step),
`endif
    .clr_cnt     (clr_cnt),
    .ram_busy    (ram_busy),
    .opcode      (opcode),
    .q           (q),
    .halted      (halted),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  // Model: mode 0 = idle in reset state, 1 = executing, 2 = halted.
  // Within an instruction, phase walks the seven-state sequence below.
  SequencerState ph [7] = '{SREAD, SLOAD1, SLOAD2, SLOAD3, SCALC, SWRITE, SNXT};
  int m_mode = 0;
  int m_phase = 0;
  bit m_stop = 0;
  bit m_single = 0;
  bit m_run_prev = 0;
  int m_cyc = 0;
  int m_ins = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_phase = 0; m_stop = 0; m_single = 0;
      m_run_prev = 0; m_cyc = 0; m_ins = 0;
    end else begin
      if (clr_cnt) begin
        m_cyc = 0;
        m_ins = 0;
      end else if (m_mode == 1) begin
        m_cyc = (m_cyc + 1) % MOD;
        if (m_phase == 6) m_ins = (m_ins + 1) % MOD;
      end
      case (m_mode)
        0: if (run) begin m_mode = 1; m_phase = 0; end
        1: begin
          if (halt_req) m_stop = 1;
          if (m_phase == 0) begin
            m_phase = 1;
          end else if (m_phase == 6) begin
            if (m_stop || m_single) begin m_mode = 2; m_stop = 0; end
            else m_phase = 0;
          end else if (!ram_busy) begin
            if (m_phase == 5 && opcode == HALT_OP) m_stop = 1;
            m_phase = m_phase + 1;
          end
        end
        default: begin
          if (halt_req) begin
          end else if (step) begin
            m_mode = 1; m_phase = 0; m_single = 1;
          end else if (run && !m_run_prev) begin
            m_mode = 1; m_phase = 0; m_single = 0;
          end
        end
      endcase
      m_run_prev = run;
    end
  end

  function automatic SequencerState model_q();
    if (m_mode == 0) return SRST;
    if (m_mode == 2) return SHALT;
    return ph[m_phase];
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      checks += 4;
      if (q !== model_q()) begin
        errors++;
        $display("FAIL model_q t=%0t actual=%0d required=%0d", $time, q, model_q());
      end
      if (halted !== (m_mode == 2)) begin
        errors++;
        $display("FAIL model_halted t=%0t actual=%0b required=%0b", $time, halted, m_mode == 2);
      end
      if (int'(cycle_count) != m_cyc) begin
        errors++;
        $display("FAIL model_cycle_count t=%0t actual=%0d required=%0d", $time, cycle_count, m_cyc);
      end
      if (int'(instr_count) != m_ins) begin
        errors++;
        $display("FAIL model_instr_count t=%0t actual=%0d required=%0d", $time, instr_count, m_ins);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_q(input SequencerState s);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (q == s) found = 1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_q t=%0t actual=%0d required=%0d", $time, q, s);
    end
  endtask

  initial begin
    // Reset and idle start
    repeat (2) tick();
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_q", int'(q), int'(SRST));
    end
    chk("idle_cycle", int'(cycle_count), 0);
    chk("idle_instr", int'(instr_count), 0);
    run = 1'b1;
    tick();
    chk("start_sread", int'(q), int'(SREAD));
    repeat (6) tick();
    chk("start_snxt", int'(q), int'(SNXT));
    tick();
    chk("start_instr", int'(instr_count), 1);
    chk("start_cycle", int'(cycle_count), 7);
    $display("[%0t] reset/start instr=%0d cycles=%0d", $time, instr_count, cycle_count);

    // Three stall cycles in SLOAD2
    wait_q(SNXT);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    tick();
    tick();
    chk("stall_enter", int'(q), int'(SLOAD2));
    ram_busy = 1'b1;
    repeat (3) tick();
    chk("stall_hold", int'(q), int'(SLOAD2));
    ram_busy = 1'b0;
    wait_q(SNXT);
    tick();
    chk("stall_cycle", int'(cycle_count), 10);
    chk("stall_instr", int'(instr_count), 1);
    $display("[%0t] stall instr cycles=%0d", $time, cycle_count);

    // halt_req mid-instruction, then resume on a run edge
    tick();
    chk("hreq_sload1", int'(q), int'(SLOAD1));
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_q(SNXT);
    tick();
    chk("hreq_shalt", int'(q), int'(SHALT));
    chk("hreq_halted", int'(halted), 1);
    run = 1'b0;
    tick();
    chk("hreq_stay", int'(q), int'(SHALT));
    run = 1'b1;
    tick();
    chk("hreq_resume", int'(q), int'(SREAD));
    $display("[%0t] halt request and resume", $time);

    // Halt opcode, then a normal opcode runs continuously
    opcode = 8'hFF;
    wait_q(SNXT);
    tick();
    chk("hop_shalt", int'(q), int'(SHALT));
    opcode = 8'h01;
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    chk("hop_resume", int'(q), int'(SREAD));
    for (int i = 0; i < 2; i++) begin
      wait_q(SNXT);
      tick();
      chk("hop_continue", int'(q), int'(SREAD));
    end
    $display("[%0t] halt opcode", $time);

`ifdef SEQ_STEP_EN
    // Single step from SHALT, and halt_req beating step
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    wait_q(SNXT);
    tick();
    chk("step_halted", int'(q), int'(SHALT));
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    chk("step_sread", int'(q), int'(SREAD));
    wait_q(SNXT);
    tick();
    chk("step_back", int'(q), int'(SHALT));
    chk("step_instr", int'(instr_count), 1);
    step = 1'b1;
    halt_req = 1'b1;
    tick();
    step = 1'b0;
    halt_req = 1'b0;
    chk("step_blocked", int'(q), int'(SHALT));
    tick();
    chk("step_blocked2", int'(q), int'(SHALT));
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    chk("step_run_resume", int'(q), int'(SREAD));
    $display("[%0t] single step", $time);
`endif

    // Counter wrap after 16 instructions, then clear during SCALC
    wait_q(SNXT);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_q(SNXT);
      tick();
      if (i == 14) chk("wrap_15", int'(instr_count), 15);
    end
    chk("wrap_instr", int'(instr_count), 0);
    wait_q(SCALC);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_cycle", int'(cycle_count), 0);
    chk("clr_instr", int'(instr_count), 0);
    $display("[%0t] counter wrap and clear", $time);

    // Asynchronous reset mid-instruction
    wait_q(SLOAD3);
    #2 rstn = 1'b0;
    #1;
    chk("areset_q", int'(q), int'(SRST));
    chk("areset_halted", int'(halted), 0);
    chk("areset_cycle", int'(cycle_count), 0);
    $display("[%0t] async reset", $time);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
